// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (I) and
// data access (D). Data has priority over fetch. All memory-side request
// fields are registered at the grant edge and held until the transaction
// completes.
// Optional feature: define ARB_STARVE_GUARD_EN to enable the fetch starvation
// guard. After STARVE_LIMIT consecutive data grants taken while a fetch was
// pending, the pending fetch wins the next arbitration.
module mem_port_arbiter #(
  parameter logic [2:0] STARVE_LIMIT = 3'd4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        I_READ,
  input  logic [31:0] I_ADDRESS,
  output logic        I_BUSYWAIT,
  output logic [31:0] I_READDATA,
  input  logic        D_READ,
  input  logic        D_WRITE,
  input  logic [31:0] D_ADDRESS,
  input  logic [31:0] D_WRITEDATA,
  input  logic [2:0]  D_FUNC3,
  output logic        D_BUSYWAIT,
  output logic [31:0] D_READDATA,
  output logic        M_READ,
  output logic        M_WRITE,
  output logic [31:0] M_ADDRESS,
  output logic [31:0] M_WRITEDATA,
  output logic [2:0]  M_FUNC3,
  input  logic [31:0] M_READDATA,
  input  logic        M_BUSYWAIT
);

  typedef enum logic [2:0] {
    IDLE,
    SERV_D,
    SERV_I,
    DONE_D,
    DONE_I
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_d_req;
  logic        w_grant_d;
  logic        w_grant_i;
  logic        w_force_i;
  logic        w_mem_done;

  logic        r_m_read;
  logic        r_m_write;
  logic [31:0] r_m_address;
  logic [31:0] r_m_writedata;
  logic [2:0]  r_m_func3;
  logic [31:0] r_i_readdata;
  logic [31:0] r_d_readdata;

  assign w_d_req    = D_READ | D_WRITE;
  assign w_mem_done = ((r_state == SERV_D) || (r_state == SERV_I)) && !M_BUSYWAIT;

`ifdef ARB_STARVE_GUARD_EN
  logic [2:0] r_starve_cnt;

  assign w_force_i = I_READ && (r_starve_cnt == STARVE_LIMIT);

  // Starvation counter: counts data grants taken over a pending fetch.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_starve_cnt <= '0;
    end else if (r_state == IDLE) begin
      if (w_grant_i) begin
        r_starve_cnt <= '0;
      end else if (w_grant_d && I_READ) begin
        if (r_starve_cnt != STARVE_LIMIT) begin
          r_starve_cnt <= r_starve_cnt + 3'd1;
        end
      end else if (!I_READ) begin
        r_starve_cnt <= '0;
      end
    end
  end
`else
  logic w_unused_limit;

  assign w_force_i      = 1'b0;
  assign w_unused_limit = ^STARVE_LIMIT;
`endif

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and arbitration decision.
  always_comb begin
    w_next    = r_state;
    w_grant_d = 1'b0;
    w_grant_i = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_d_req && !w_force_i) begin
          w_grant_d = 1'b1;
          w_next    = SERV_D;
        end else if (I_READ) begin
          w_grant_i = 1'b1;
          w_next    = SERV_I;
        end
      end
      SERV_D: begin
        if (!M_BUSYWAIT) begin
          w_next = DONE_D;
        end
      end
      SERV_I: begin
        if (!M_BUSYWAIT) begin
          w_next = DONE_I;
        end
      end
      DONE_D:  w_next = IDLE;
      DONE_I:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Memory request fields: loaded at grant, strobes cleared at completion.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_m_read      <= 1'b0;
      r_m_write     <= 1'b0;
      r_m_address   <= '0;
      r_m_writedata <= '0;
      r_m_func3     <= '0;
    end else if (w_grant_d) begin
      // Simultaneous read and write is served as a write.
      r_m_read      <= D_READ & ~D_WRITE;
      r_m_write     <= D_WRITE;
      r_m_address   <= D_ADDRESS;
      r_m_writedata <= D_WRITEDATA;
      r_m_func3     <= D_FUNC3;
    end else if (w_grant_i) begin
      r_m_read      <= 1'b1;
      r_m_write     <= 1'b0;
      r_m_address   <= I_ADDRESS;
      r_m_func3     <= 3'b010;
    end else if (w_mem_done) begin
      r_m_read      <= 1'b0;
      r_m_write     <= 1'b0;
    end
  end

  // Read data capture on completion of a read for the owning requester.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_i_readdata <= '0;
      r_d_readdata <= '0;
    end else if (w_mem_done && r_m_read) begin
      if (r_state == SERV_D) begin
        r_d_readdata <= M_READDATA;
      end else begin
        r_i_readdata <= M_READDATA;
      end
    end
  end

  assign I_BUSYWAIT  = I_READ  & (r_state != DONE_I);
  assign D_BUSYWAIT  = w_d_req & (r_state != DONE_D);
  assign I_READDATA  = r_i_readdata;
  assign D_READDATA  = r_d_readdata;
  assign M_READ      = r_m_read;
  assign M_WRITE     = r_m_write;
  assign M_ADDRESS   = r_m_address;
  assign M_WRITEDATA = r_m_writedata;
  assign M_FUNC3     = r_m_func3;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by randomized
// traffic, all checked against a transaction-timeline reference model.
module tb_mem_port_arbiter;

  localparam logic [2:0] LIMIT = 3'd2;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        CLK;
  logic        RESET;
  logic        I_READ;
  logic [31:0] I_ADDRESS;
  logic        I_BUSYWAIT;
  logic [31:0] I_READDATA;
  logic        D_READ;
  logic        D_WRITE;
  logic [31:0] D_ADDRESS;
  logic [31:0] D_WRITEDATA;
  logic [2:0]  D_FUNC3;
  logic        D_BUSYWAIT;
  logic [31:0] D_READDATA;
  logic        M_READ;
  logic        M_WRITE;
  logic [31:0] M_ADDRESS;
  logic [31:0] M_WRITEDATA;
  logic [2:0]  M_FUNC3;
  logic [31:0] M_READDATA;
  logic        M_BUSYWAIT;

  int checks = 0;
  int errors = 0;

  // Reference model: one transaction at a time on a cycle timeline.
  // Grant at cycle g, memory busy k cycles, SERV = g+1..g+k+1, DONE = g+k+2.
  bit          act;
  bit          act_d;
  bit          act_rd;
  bit          act_wr;
  int          g;
  int          k;
  int          done_c;
  int          cyc;
  int          cnt;
  int          next_k;
  int          mw_cycles;
  logic [31:0] next_mdata;
  logic [31:0] mdata;
  logic [31:0] e_addr;
  logic [31:0] e_wd;
  logic [2:0]  e_f3;
  logic [31:0] e_ird;
  logic [31:0] e_drd;
  byte         glog[$];

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .I_READ     (I_READ),
    .I_ADDRESS  (I_ADDRESS),
    .I_BUSYWAIT (I_BUSYWAIT),
    .I_READDATA (I_READDATA),
    .D_READ     (D_READ),
    .D_WRITE    (D_WRITE),
    .D_ADDRESS  (D_ADDRESS),
    .D_WRITEDATA(D_WRITEDATA),
    .D_FUNC3    (D_FUNC3),
    .D_BUSYWAIT (D_BUSYWAIT),
    .D_READDATA (D_READDATA),
    .M_READ     (M_READ),
    .M_WRITE    (M_WRITE),
    .M_ADDRESS  (M_ADDRESS),
    .M_WRITEDATA(M_WRITEDATA),
    .M_FUNC3    (M_FUNC3),
    .M_READDATA (M_READDATA),
    .M_BUSYWAIT (M_BUSYWAIT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    act    = 1'b0;
    e_addr = '0;
    e_wd   = '0;
    e_f3   = '0;
    e_ird  = '0;
    e_drd  = '0;
    cnt    = 0;
  endtask

  // Assert reset mid-cycle, check the asynchronous effect, release after an edge.
  task automatic do_reset();
    I_READ      = 1'b0;
    I_ADDRESS   = '0;
    D_READ      = 1'b0;
    D_WRITE     = 1'b0;
    D_ADDRESS   = '0;
    D_WRITEDATA = '0;
    D_FUNC3     = '0;
    M_BUSYWAIT  = 1'b1;
    M_READDATA  = '0;
    RESET       = 1'b1;
    #1;
    chk("rst_m_read",  32'(M_READ), 32'd0);
    chk("rst_m_write", 32'(M_WRITE), 32'd0);
    chk("rst_m_addr",  M_ADDRESS, 32'd0);
    chk("rst_m_wdata", M_WRITEDATA, 32'd0);
    chk("rst_m_func3", 32'(M_FUNC3), 32'd0);
    chk("rst_i_rdata", I_READDATA, 32'd0);
    chk("rst_d_rdata", D_READDATA, 32'd0);
    model_reset();
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    cyc   = 0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance.
  task automatic step(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                      input logic [31:0] da, input logic [31:0] dwd, input logic [2:0] f3);
    bit in_win;
    bit force_i;
    I_READ      = ir;
    I_ADDRESS   = ia;
    D_READ      = dr;
    D_WRITE     = dw;
    D_ADDRESS   = da;
    D_WRITEDATA = dwd;
    D_FUNC3     = f3;
    in_win      = act && (cyc >= g + 1) && (cyc <= g + k + 1);
    M_BUSYWAIT  = in_win ? (cyc < g + k + 1) : 1'($urandom);
    M_READDATA  = in_win ? mdata : $urandom;
    #1;
    chk("m_read",  32'(M_READ),  32'(in_win & act_rd));
    chk("m_write", 32'(M_WRITE), 32'(in_win & act_wr));
    chk("m_addr",  M_ADDRESS, e_addr);
    chk("m_func3", 32'(M_FUNC3), 32'(e_f3));
    if (in_win && act_wr) chk("m_wdata", M_WRITEDATA, e_wd);
    chk("i_busy", 32'(I_BUSYWAIT), 32'(ir & ~(act & ~act_d & (cyc == done_c))));
    chk("d_busy", 32'(D_BUSYWAIT), 32'((dr | dw) & ~(act & act_d & (cyc == done_c))));
    chk("i_rdata", I_READDATA, e_ird);
    chk("d_rdata", D_READDATA, e_drd);
    if (M_WRITE) mw_cycles++;
    if (in_win && (cyc == g + k + 1) && act_rd) begin
      if (act_d) e_drd = mdata;
      else       e_ird = mdata;
    end
    if (act && (cyc == done_c)) begin
      act = 1'b0;
    end else if (!act) begin
      force_i = GUARD && (cnt == int'(LIMIT)) && ir;
      if ((dr | dw) && !force_i) begin
        act = 1'b1; act_d = 1'b1; act_wr = dw; act_rd = !dw;
        e_addr = da; e_wd = dwd; e_f3 = f3;
        if (ir) begin
          if (cnt < int'(LIMIT)) cnt++;
        end else begin
          cnt = 0;
        end
        glog.push_back(8'h44);
      end else if (ir) begin
        act = 1'b1; act_d = 1'b0; act_wr = 1'b0; act_rd = 1'b1;
        e_addr = ia; e_f3 = 3'b010;
        cnt = 0;
        glog.push_back(8'h49);
      end else begin
        cnt = 0;
      end
      if (act) begin
        g = cyc; k = next_k; done_c = cyc + next_k + 2; mdata = next_mdata;
      end
    end
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  initial begin
    cyc = 0; g = 0; k = 0; done_c = 0; mw_cycles = 0;
    act_d = 1'b0; act_rd = 1'b0; act_wr = 1'b0;
    next_k = 0; next_mdata = '0; mdata = '0;
    do_reset();

    // Fetch from 0x40, memory busy 2 cycles.
    next_k = 2; next_mdata = 32'h00500093;
    repeat (5) step(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    chk("fetch_data", I_READDATA, 32'h00500093);

    // Byte store, k=0: single-cycle write strobe, load data untouched.
    next_k = 0; next_mdata = 32'h5A5A5A5A; mw_cycles = 0;
    repeat (3) step(1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 3'b000);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    chk("write_pulse", 32'(mw_cycles), 32'd1);
    chk("write_keeps_drd", D_READDATA, 32'd0);

    // Fetch and load raised together: load first, then fetch.
    glog.delete();
    next_k = 1; next_mdata = 32'h11112222;
    repeat (4) step(1'b1, 32'h80, 1'b1, 1'b0, 32'h200, 32'h0, 3'b010);
    next_mdata = 32'h33334444;
    repeat (4) step(1'b1, 32'h80, 1'b0, 1'b0, 32'h200, 32'h0, 3'b010);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    chk("prio_count", 32'(glog.size()), 32'd2);
    chk("prio_first", 32'(glog[0]), 32'h44);
    chk("prio_second", 32'(glog[1]), 32'h49);
    chk("prio_drd", D_READDATA, 32'h11112222);
    chk("prio_ird", I_READDATA, 32'h33334444);

    // Read and write together: served as a write only.
    next_k = 1; mw_cycles = 0;
    repeat (4) step(1'b0, 32'h0, 1'b1, 1'b1, 32'h300, 32'hCAFEF00D, 3'b001);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    chk("rw_write_cycles", 32'(mw_cycles), 32'd2);

    // Reset while a load is stalled in service.
    next_k = 3; next_mdata = 32'h77778888;
    repeat (2) step(1'b0, 32'h0, 1'b1, 1'b0, 32'h400, 32'h0, 3'b100);
    do_reset();
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      next_k     = int'($urandom_range(0, 3));
      next_mdata = $urandom;
      step(1'($urandom_range(0, 9) < 6), $urandom, 1'($urandom_range(0, 9) < 4),
           1'($urandom_range(0, 9) < 3), $urandom, $urandom, 3'($urandom));
    end

    // Continuous fetch and load pressure: grant order.
    do_reset();
    glog.delete();
    next_k = 0; next_mdata = 32'h0BADF00D;
    repeat (18) step(1'b1, 32'h500, 1'b1, 1'b0, 32'h600, 32'h0, 3'b010);
    chk("starve_count", 32'(glog.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < glog.size())
        chk($sformatf("starve_grant%0d", i), 32'(glog[i]),
            (GUARD && (i % 3 == 2)) ? 32'h49 : 32'h44);
    end
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
